// File: rtl/cbm2_pkg.sv
// cbm2_pkg: shared types and constants for the CBM2 memory arbiter
package cbm2_pkg;
  localparam int ADDR_W = 25;
  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {VID, CPU, LD} req_id_t;
endpackage

// File: rtl/cbm2_mem_arbiter.sv
// cbm2_mem_arbiter: video/CPU/loader arbiter onto a single ready-handshake memory port
module cbm2_mem_arbiter
  import cbm2_pkg::*;
#(
  parameter int VID_BURST_MAX = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_wdata,
  output logic              ld_ack,
  output logic [7:0]        rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              err
);
  localparam int BW = $clog2(VID_BURST_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  req_id_t gnt, pick;
  logic rr_ld, vid_win, timeout;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] wcnt;
  // video loses to a waiting CPU once its burst allowance is spent
  always_comb begin
    vid_win = vid_req && !(cpu_req && bcnt == BW'(VID_BURST_MAX));
    pick = vid_win ? VID : (ld_req && (!cpu_req || rr_ld)) ? LD : CPU;
    timeout = wcnt == TW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      gnt <= VID;
      rr_ld <= 1'b0;
      bcnt <= '0;
      wcnt <= '0;
      err <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rdata <= '0;
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      ld_ack <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!cpu_req) bcnt <= '0;
          if (vid_req || cpu_req || ld_req) begin
            state <= ISSUE;
            gnt <= pick;
            mem_req <= 1'b1;
            mem_addr <= pick == VID ? vid_addr : pick == CPU ? cpu_addr : ld_addr;
            mem_we <= pick == LD ? 1'b1 : pick == CPU ? cpu_we : 1'b0;
            mem_wdata <= pick == LD ? ld_wdata : pick == CPU ? cpu_wdata : 8'h00;
            if (pick == VID && cpu_req) bcnt <= bcnt + 1'b1;
            if (pick != VID) begin
              bcnt <= '0;
              rr_ld <= !rr_ld;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
          mem_req <= 1'b0;
          wcnt <= '0;
        end
        WAIT: begin
          if (mem_ready || timeout) begin
            state <= DONE;
            rdata <= !mem_ready ? TIMEOUT_DATA : mem_we ? 8'h00 : mem_rdata;
            err <= err || !mem_ready;
            vid_ack <= gnt == VID;
            cpu_ack <= gnt == CPU;
            ld_ack <= gnt == LD;
          end else wcnt <= wcnt + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          vid_ack <= 1'b0;
          cpu_ack <= 1'b0;
          ld_ack <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cbm2_mem_arbiter.sv
// tb_cbm2_mem_arbiter: directed scoreboard bench for the CBM2 memory arbiter
module tb_cbm2_mem_arbiter;
  import cbm2_pkg::*;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, ld_req = 1'b0, mem_ready = 1'b0;
  logic [24:0] vid_addr = '0, cpu_addr = '0, ld_addr = '0;
  logic [7:0] cpu_wdata = '0, ld_wdata = '0, mem_rdata = '0;
  logic vid_ack, cpu_ack, ld_ack, mem_req, mem_we, err;
  logic [24:0] mem_addr;
  logic [7:0] mem_wdata, rdata;
  int n_chk = 0, n_fail = 0, cyc = 0;
  typedef struct {
    req_id_t id;
    logic [24:0] addr;
    logic we;
    logic [7:0] wdata;
    logic [7:0] mrd;
    logic [7:0] rd;
  } item_t;
  item_t sb[$];

  cbm2_mem_arbiter dut (
    .clk_sys(clk_sys), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected read data is derived here: timeout -> FF, write -> 00, else what memory returns
  task automatic push(input req_id_t id, input logic [24:0] a, input logic we,
                      input logic [7:0] wd, input logic [7:0] mrd, input logic to);
    item_t it;
    it.id = id;
    it.addr = a;
    it.we = we;
    it.wdata = wd;
    it.mrd = mrd;
    it.rd = to ? 8'hFF : we ? 8'h00 : mrd;
    sb.push_back(it);
  endtask

  // memory responder: ready after d WAIT cycles (d<0: never), returns in the IDLE after DONE
  task automatic serve(input int d, input logic late_ld, output int iss_at, output int ack_at);
    item_t it;
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk("mem_req_seen", mem_req, 1);
    iss_at = cyc;
    it = sb.pop_front();
    chk("mem_addr", mem_addr, it.addr);
    chk("mem_we", mem_we, it.we);
    if (it.we) chk("mem_wdata", mem_wdata, it.wdata);
    mem_ready = 1'b1;
    mem_rdata = ~it.mrd;
    tick();
    chk("mem_req_pulse", mem_req, 0);
    chk("addr_hold", mem_addr, it.addr);
    if (late_ld) ld_req = 1'b1;
    n = 0;
    do begin
      mem_ready = (n == d);
      mem_rdata = it.mrd;
      tick();
      n++;
    end while (!(vid_ack | cpu_ack | ld_ack) && n < 400);
    mem_ready = 1'b0;
    ack_at = cyc;
    chk("ack", {vid_ack, cpu_ack, ld_ack}, it.id == VID ? 3'b100 : it.id == CPU ? 3'b010 : 3'b001);
    chk("rdata", rdata, it.rd);
    tick();
    chk("ack_one_cycle", {vid_ack, cpu_ack, ld_ack}, 0);
  endtask

  initial begin
    int ia, aa, ia2, aa2, t0, n;
    logic flag;
    repeat (3) tick();
    chk("rst_ack", {vid_ack, cpu_ack, ld_ack}, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    tick();
    // single CPU read with fixed latency
    cpu_addr = 25'h0F_D000;
    cpu_req = 1'b1;
    push(CPU, 25'h0F_D000, 1'b0, 8'h00, 8'h5A, 1'b0);
    t0 = cyc;
    chk("cpu_rd_idle_req", mem_req, 0);
    serve(0, 1'b0, ia, aa);
    chk("cpu_rd_issue_lat", ia - t0, 1);
    chk("cpu_rd_ack_lat", aa - t0, 3);
    cpu_req = 1'b0;
    // CPU write, ready after two extra WAIT cycles
    cpu_addr = 25'h1AB_CDEF;
    cpu_we = 1'b1;
    cpu_wdata = 8'h3C;
    cpu_req = 1'b1;
    push(CPU, 25'h1AB_CDEF, 1'b1, 8'h3C, 8'h77, 1'b0);
    serve(2, 1'b0, ia, aa);
    chk("cpu_wr_wait", aa - ia, 4);
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    // video starvation guard: V,V,V,V,C,V,V,V,V,C
    vid_addr = 25'h002_0000;
    cpu_addr = 25'h000_1234;
    for (int i = 0; i < 10; i++)
      push(i % 5 == 4 ? CPU : VID, i % 5 == 4 ? 25'h000_1234 : 25'h002_0000, 1'b0, 8'h00, 8'(i * 17 + 1), 1'b0);
    vid_req = 1'b1;
    cpu_req = 1'b1;
    for (int i = 0; i < 10; i++) serve(0, 1'b0, ia, aa);
    vid_req = 1'b0;
    cpu_req = 1'b0;
    // round robin between CPU and loader from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_addr = 25'h0C0_0000;
    ld_addr = 25'h1F0_0010;
    ld_wdata = 8'hE1;
    push(CPU, 25'h0C0_0000, 1'b0, 8'h00, 8'h21, 1'b0);
    push(LD, 25'h1F0_0010, 1'b1, 8'hE1, 8'h22, 1'b0);
    push(CPU, 25'h0C0_0000, 1'b0, 8'h00, 8'h23, 1'b0);
    push(LD, 25'h1F0_0010, 1'b1, 8'hE1, 8'h24, 1'b0);
    cpu_req = 1'b1;
    ld_req = 1'b1;
    for (int i = 0; i < 4; i++) serve(0, 1'b0, ia, aa);
    cpu_req = 1'b0;
    ld_req = 1'b0;
    // loader request rising during a video WAIT
    vid_addr = 25'h003_0040;
    ld_addr = 25'h010_0002;
    ld_wdata = 8'h9D;
    push(VID, 25'h003_0040, 1'b0, 8'h00, 8'hC3, 1'b0);
    push(LD, 25'h010_0002, 1'b1, 8'h9D, 8'h44, 1'b0);
    vid_req = 1'b1;
    serve(0, 1'b1, ia, aa);
    vid_req = 1'b0;
    serve(0, 1'b0, ia2, aa2);
    chk("late_ld_lat", aa2 - aa, 4);
    ld_req = 1'b0;
    // timeout with mem_ready never asserted
    chk("err_pre", err, 0);
    cpu_addr = 25'h100_0000;
    cpu_req = 1'b1;
    push(CPU, 25'h100_0000, 1'b0, 8'h00, 8'h11, 1'b1);
    serve(-1, 1'b0, ia, aa);
    chk("timeout_wait", aa - ia, 256);
    chk("err_set", err, 1);
    cpu_req = 1'b0;
    ld_addr = 25'h000_0100;
    ld_wdata = 8'h55;
    ld_req = 1'b1;
    push(LD, 25'h000_0100, 1'b1, 8'h55, 8'h66, 1'b0);
    serve(1, 1'b0, ia, aa);
    ld_req = 1'b0;
    chk("err_sticky", err, 1);
    // reset asserted mid-WAIT aborts silently
    cpu_addr = 25'h0AA_AAAA;
    cpu_req = 1'b1;
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk("rw_issue", mem_req, 1);
    tick();
    reset = 1'b1;
    cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    chk("rw_err", err, 0);
    chk("rw_mem_req", mem_req, 0);
    chk("rw_mem_addr", mem_addr, 0);
    chk("rw_rdata", rdata, 0);
    chk("rw_ack", {vid_ack, cpu_ack, ld_ack}, 0);
    flag = 1'b0;
    repeat (8) begin
      tick();
      flag = flag | vid_ack | cpu_ack | ld_ack | mem_req;
    end
    chk("rw_quiet", flag, 0);
    cpu_addr = 25'h055_5555;
    cpu_req = 1'b1;
    push(CPU, 25'h055_5555, 1'b0, 8'h00, 8'hB7, 1'b0);
    serve(0, 1'b0, ia, aa);
    cpu_req = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
